// File: rtl/blk_buf_pingpong_pkg.sv
// Shared sizing defaults and bit-placement helper for the ping-pong block loader.
// Row 0 / column 0 always sits in the most significant word of a flattened block.
package blk_pkg;

    localparam int DEF_WORD_WIDTH = 8;
    localparam int DEF_BLK_DIM    = 4;
    localparam int DEF_ROW_W      = DEF_WORD_WIDTH * DEF_BLK_DIM;
    localparam int DEF_BLK_W      = DEF_ROW_W * DEF_BLK_DIM;
    localparam int DEF_CNT_W      = $clog2(DEF_BLK_DIM);

    // LSB position of word (r,c) inside a row-major, MSB-first flattened block
    function automatic int word_lsb(input int r, input int c, input int ww, input int dim);
        return (dim * dim - 1 - (r * dim + c)) * ww;
    endfunction

endpackage

// File: rtl/blk_buf_pingpong_if.sv
// Row-stream input and block-output handshake bundle of the ping-pong loader.
// master = producer/consumer side, slave = the buffer itself.
interface blk_buf_pingpong_if
    import blk_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int BLK_DIM    = DEF_BLK_DIM
);

    logic                                  in_valid;
    logic                                  in_ready;
    logic                                  in_sob;
    logic [WORD_WIDTH*BLK_DIM-1:0]         in_row;
    logic                                  out_valid;
    logic                                  out_release;
    logic [WORD_WIDTH*BLK_DIM*BLK_DIM-1:0] pe_block;
    logic                                  sob_err;

    modport master (
        output in_valid, in_sob, in_row, out_release,
        input  in_ready, out_valid, pe_block, sob_err
    );

    modport slave (
        input  in_valid, in_sob, in_row, out_release,
        output in_ready, out_valid, pe_block, sob_err
    );

endinterface

// File: rtl/blk_buf_pingpong_bank.sv
// One block bank: BLK_DIM row registers, single row write port, flat read port.
// Contents clear on reset only; flush leaves data alone.
module blk_bank
    import blk_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int BLK_DIM    = DEF_BLK_DIM
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_we,
    input  logic [$clog2(BLK_DIM)-1:0]            i_addr,
    input  logic [WORD_WIDTH*BLK_DIM-1:0]         i_row,
    output logic [WORD_WIDTH*BLK_DIM*BLK_DIM-1:0] o_data
);

    localparam int ROW_W = WORD_WIDTH * BLK_DIM;
    localparam int CNT_W = $clog2(BLK_DIM);

    logic [ROW_W-1:0] r_rows [BLK_DIM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BLK_DIM; i++) begin
                r_rows[i] <= '0;
            end
        end else if (i_we) begin
            for (int i = 0; i < BLK_DIM; i++) begin
                if (i_addr == CNT_W'(i)) begin
                    r_rows[i] <= i_row;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BLK_DIM; gi++) begin : g_flat
            assign o_data[word_lsb(gi, BLK_DIM - 1, WORD_WIDTH, BLK_DIM) +: ROW_W] = r_rows[gi];
        end
    endgenerate

endmodule

// File: rtl/blk_buf_pingpong.sv
// Double-buffered BLK_DIM x BLK_DIM block loader: fills one bank row by row
// while the PE array reads the other; supports release, sob resync and flush.
module blk_buf_pingpong
    import blk_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int BLK_DIM    = DEF_BLK_DIM
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    blk_buf_pingpong_if.slave  bus
);

    localparam int BLK_W = WORD_WIDTH * BLK_DIM * BLK_DIM;
    localparam int CNT_W = $clog2(BLK_DIM);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(BLK_DIM - 1);

    logic             r_wr_bank, r_wr_bank_next;
    logic             r_rd_bank, r_rd_bank_next;
    logic [CNT_W-1:0] r_wr_row,  r_wr_row_next;
    logic [1:0]       r_full,    r_full_next;
    logic             r_sob_err, r_sob_err_next;

    logic             w_accept;
    logic             w_resync;
    logic             w_last;
    logic             w_release;
    logic [CNT_W-1:0] w_eff_row;
    logic [1:0]       w_bank_we;
    logic [BLK_W-1:0] w_bank_data [2];

    assign bus.in_ready  = !r_full[r_wr_bank];
    assign bus.out_valid = r_full[r_rd_bank];
    assign bus.pe_block  = w_bank_data[r_rd_bank];
    assign bus.sob_err   = r_sob_err;

    assign w_accept  = bus.in_valid & bus.in_ready;
    assign w_release = bus.out_release & bus.out_valid;
    // A mid-block sob restarts the fill at row 0 of the same bank
    assign w_resync  = bus.in_sob & (r_wr_row != '0);
    assign w_eff_row = w_resync ? '0 : r_wr_row;
    assign w_last    = !w_resync && (r_wr_row == LAST_ROW);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            assign w_bank_we[gi] = w_accept & !flush & (r_wr_bank == 1'(gi));

            blk_bank #(
                .WORD_WIDTH (WORD_WIDTH),
                .BLK_DIM    (BLK_DIM)
            ) u_bank (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_we   (w_bank_we[gi]),
                .i_addr (w_eff_row),
                .i_row  (bus.in_row),
                .o_data (w_bank_data[gi])
            );
        end
    endgenerate

    always_comb begin
        r_wr_bank_next = r_wr_bank;
        r_rd_bank_next = r_rd_bank;
        r_wr_row_next  = r_wr_row;
        r_full_next    = r_full;
        r_sob_err_next = r_sob_err;
        if (flush) begin
            r_wr_bank_next = 1'b0;
            r_rd_bank_next = 1'b0;
            r_wr_row_next  = '0;
            r_full_next    = 2'b00;
            r_sob_err_next = 1'b0;
        end else begin
            if (w_release) begin
                r_full_next[r_rd_bank] = 1'b0;
                r_rd_bank_next         = !r_rd_bank;
            end
            // Release and completion never hit the same bank: a full bank blocks writes
            if (w_accept) begin
                if (w_resync) begin
                    r_wr_row_next  = CNT_W'(1);
                    r_sob_err_next = 1'b1;
                end else if (w_last) begin
                    r_full_next[r_wr_bank] = 1'b1;
                    r_wr_bank_next         = !r_wr_bank;
                    r_wr_row_next          = '0;
                end else begin
                    r_wr_row_next = r_wr_row + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_row  <= '0;
            r_full    <= 2'b00;
            r_sob_err <= 1'b0;
        end else begin
            r_wr_bank <= r_wr_bank_next;
            r_rd_bank <= r_rd_bank_next;
            r_wr_row  <= r_wr_row_next;
            r_full    <= r_full_next;
            r_sob_err <= r_sob_err_next;
        end
    end

endmodule

// File: tb/tb_blk_buf_pingpong.sv
// Scoreboard bench for blk_buf_pingpong: completed blocks are queued as rows are
// accepted and compared against pe_block whenever the consumer releases a bank.
module tb_blk_buf_pingpong;
    import blk_pkg::*;

    localparam int WW = DEF_WORD_WIDTH;
    localparam int BD = DEF_BLK_DIM;
    localparam int RW = WW * BD;
    localparam int BW = RW * BD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    blk_buf_pingpong_if #(.WORD_WIDTH(WW), .BLK_DIM(BD)) bus ();

    blk_buf_pingpong #(.WORD_WIDTH(WW), .BLK_DIM(BD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model of the row-to-block assembly
    logic [BW-1:0] sb_q [$];
    logic [RW-1:0] m_rows [BD];
    int            m_row     = 0;
    bit            m_sob_err = 1'b0;
    int            stalls    = 0;

    task automatic model_accept(input logic [RW-1:0] row, input bit sob);
        logic [BW-1:0] blk;
        if (sob && m_row != 0) begin
            m_row     = 0;
            m_sob_err = 1'b1;
        end
        m_rows[m_row] = row;
        if (m_row == BD - 1) begin
            blk = '0;
            for (int r = 0; r < BD; r++) blk[word_lsb(r, BD - 1, WW, BD) +: RW] = m_rows[r];
            sb_q.push_back(blk);
            m_row = 0;
        end else begin
            m_row++;
        end
    endtask

    task automatic model_reset();
        m_row     = 0;
        m_sob_err = 1'b0;
        sb_q.delete();
    endtask

    task automatic send_row(input logic [RW-1:0] row, input bit sob);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_row   = row;
        bus.in_sob   = sob;
        #4;
        while (!bus.in_ready && n < 100) begin
            stalls++;
            n++;
            @(negedge clk);
            #4;
        end
        if (bus.in_ready) model_accept(row, sob);
        else chk("accept_timeout", 0, 1);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sob   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic send_block(input bit do_sob);
        for (int r = 0; r < BD; r++) send_row(RW'($urandom), do_sob && r == 0);
    endtask

    // Consumer: periodic or one-shot bank release with scoreboard compare
    bit rel_on      = 1'b0;
    bit rel_oneshot = 1'b0;
    int cyc         = 0;
    int n_rel       = 0;

    initial begin
        bus.out_release = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.out_release = 1'b0;
            if (rst_n && bus.out_valid && (rel_oneshot || (rel_on && cyc % 4 == 0))) begin
                if (sb_q.size() == 0) chk("sb_empty", 0, 1);
                else chk("pe_block", bus.pe_block, sb_q.pop_front());
                $display("release %0d pe_block=%h", n_rel, bus.pe_block);
                n_rel++;
                bus.out_release = 1'b1;
                rel_oneshot     = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sob   = 1'b0;
        bus.in_row   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_pe_block", bus.pe_block, 0);
        chk("rst_sob_err", bus.sob_err, 0);

        // First block, fixed pattern
        stalls = 0;
        send_row(32'h00010203, 1'b1);
        send_row(32'h04050607, 1'b0);
        send_row(32'h08090A0B, 1'b0);
        send_row(32'h0C0D0E0F, 1'b0);
        chk("ov_pre", bus.out_valid, 0);
        idle();
        #1;
        chk("ov_rise", bus.out_valid, 1);
        chk("blk0_literal", bus.pe_block, 128'h000102030405060708090A0B0C0D0E0F);
        chk("t1_no_stall", stalls, 0);

        // Fill the second bank, then stall until a single release
        send_block(1'b1);
        idle();
        #1;
        chk("both_full_ready", bus.in_ready, 0);
        stalls = 0;
        fork
            send_row(RW'($urandom), 1'b1);
            begin
                repeat (3) @(negedge clk);
                #1;
                chk("held_ready", bus.in_ready, 0);
                rel_oneshot = 1'b1;
                @(negedge clk);
                @(negedge clk);
                #1;
                chk("post_rel_ready", bus.in_ready, 1);
                chk("post_rel_valid", bus.out_valid, 1);
                chk("post_rel_bank1", bus.pe_block, sb_q[0]);
            end
        join
        chk("stall_seen", 32'(stalls > 0), 1);
        for (int r = 1; r < BD; r++) send_row(RW'($urandom), 1'b0);
        idle();
        rel_on = 1'b1;
        drain();

        // Continuous stream, release every 4 cycles
        stalls = 0;
        for (int b = 0; b < 4; b++) send_block(1'b1);
        idle();
        chk("stream_no_stall", stalls, 0);
        drain();

        // Mid-block sob resync
        send_row(RW'(32'hAAAA0001), 1'b1);
        send_row(RW'(32'hBBBB0002), 1'b0);
        send_row(RW'(32'hCCCC0003), 1'b1);
        for (int r = 1; r < BD; r++) send_row(RW'($urandom), 1'b0);
        idle();
        #1;
        chk("sob_err_set", bus.sob_err, m_sob_err);
        drain();

        // Flush with one bank full and the other half filled
        rel_on = 1'b0;
        send_block(1'b1);
        send_row(RW'($urandom), 1'b1);
        send_row(RW'($urandom), 1'b0);
        idle();
        #1;
        chk("pre_flush_valid", bus.out_valid, 1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_reset();
        #1;
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_ready", bus.in_ready, 1);
        chk("flush_sob_err", bus.sob_err, 0);
        send_block(1'b1);
        idle();
        #1;
        chk("flush_refill_valid", bus.out_valid, 1);
        chk("flush_bank0", bus.pe_block, sb_q[0]);
        rel_on = 1'b1;
        drain();

        // Asynchronous reset in the middle of a fill
        rel_on = 1'b0;
        send_block(1'b1);
        send_row(RW'($urandom), 1'b1);
        send_row(RW'($urandom), 1'b0);
        idle();
        #1;
        chk("pre_rst_valid", bus.out_valid, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", bus.in_ready, 1);
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_pe_block", bus.pe_block, 0);
        chk("arst_sob_err", bus.sob_err, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send_block(1'b1);
        idle();
        rel_on = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
